// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling, one-entry skid buffer and IF/ID register.
// Optional macro FETCH_COUNT_EN adds a 32-bit count of instructions delivered to decode.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             JMPSel,
  input  logic [1:0]             BranchSel,
  input  logic                   eq_flag,
  input  logic                   gt_flag,
  input  logic [PC_WIDTH-1:0]    jmp_target,
  input  logic [PC_WIDTH-1:0]    reg_target,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   instr_valid
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]            fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, SKID, DISCARD} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_q, req_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] skidInstr_q, skidInstr_d;
  logic [PC_WIDTH-1:0]    skidPc_q, skidPc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcOut_q, pcOut_d;
  logic                   valid_q, valid_d;
  logic                   loadIfId;

  logic                   takenBranch;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirTarget;
  logic [PC_WIDTH-1:0]    pcPlus4;

  // The branch comes from an older instruction than the jump, so it wins.
  assign takenBranch = ((BranchSel == 2'b01) && eq_flag) || ((BranchSel == 2'b10) && gt_flag);
  assign redirect    = takenBranch || (JMPSel == 2'b01) || (JMPSel == 2'b10);
  assign pcPlus4     = pc_q + PC_WIDTH'(4);

  always_comb begin
    redirTarget = reg_target;
    if (takenBranch) begin
      redirTarget = branch_target;
    end else if (JMPSel == 2'b01) begin
      redirTarget = jmp_target;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    skidInstr_d = skidInstr_q;
    skidPc_d    = skidPc_q;
    instr_d     = instr_q;
    pcOut_d     = pcOut_q;
    valid_d     = valid_q;
    loadIfId    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        pc_d    = redirect ? redirTarget : pc_q;
        addr_d  = redirect ? redirTarget : pc_q;
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redirTarget;
          if (imem_ready) begin
            addr_d = redirTarget;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ready) begin
          pc_d   = pcPlus4;
          addr_d = pcPlus4;
          if (stall) begin
            skidInstr_d = imem_rdata;
            skidPc_d    = pc_q;
            req_d       = 1'b0;
            state_d     = SKID;
          end else begin
            instr_d  = imem_rdata;
            pcOut_d  = pc_q;
            valid_d  = 1'b1;
            loadIfId = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      SKID: begin
        if (redirect) begin
          pc_d    = redirTarget;
          addr_d  = redirTarget;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d  = skidInstr_q;
          pcOut_d  = skidPc_q;
          valid_d  = 1'b1;
          loadIfId = 1'b1;
          addr_d   = pc_q;
          req_d    = 1'b1;
          state_d  = FETCH;
        end
      end
      DISCARD: begin
        // Old address stays on the bus until memory answers; only the stored target moves.
        if (redirect) begin
          pc_d = redirTarget;
        end
        if (imem_ready) begin
          state_d = FETCH;
          addr_d  = redirect ? redirTarget : pc_q;
        end
        if (!redirect && !stall) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      valid_d = 1'b0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      skidInstr_q <= '0;
      skidPc_q    <= '0;
      instr_q     <= '0;
      pcOut_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      skidInstr_q <= skidInstr_d;
      skidPc_q    <= skidPc_d;
      instr_q     <= instr_d;
      pcOut_q     <= pcOut_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_out   = instr_q;
  assign pc_out      = pcOut_q;
  assign instr_valid = valid_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (loadIfId) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner sequences,
// and a randomized run checked against a program-order model of the delivered instruction stream.
module tb_fetch_stage;

  localparam int PW = 32;
  localparam int IW = 32;
  localparam int NV = 22;

  logic          clk;
  logic          rst;
  logic [1:0]    JMPSel;
  logic [1:0]    BranchSel;
  logic          eq_flag;
  logic          gt_flag;
  logic [PW-1:0] jmp_target;
  logic [PW-1:0] reg_target;
  logic [PW-1:0] branch_target;
  logic          stall;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr_out;
  logic [PW-1:0] pc_out;
  logic          instr_valid;
`ifdef FETCH_COUNT_EN
  logic [31:0]   fetch_count;
`endif

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   readyMode   = 0;
  int   memDelay    = 0;
  int   waitCnt     = 0;
  logic rndReady    = 1'b0;
  logic scramble    = 1'b0;

  typedef struct {
    logic        stall;
    logic [1:0]  js;
    logic [1:0]  bs;
    logic        eq;
    logic        gt;
    logic [31:0] jt;
    logic [31:0] rt;
    logic [31:0] bt;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs[NV];

  fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .JMPSel       (JMPSel),
    .BranchSel    (BranchSel),
    .eq_flag      (eq_flag),
    .gt_flag      (gt_flag),
    .jmp_target   (jmp_target),
    .reg_target   (reg_target),
    .branch_target(branch_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: either data equals address, or a scrambled word so misrouted data shows up.
  function automatic logic [31:0] memWord(input logic [31:0] a, input logic scr);
    return scr ? ((a ^ 32'hC3A5_0000) + 32'h0000_0011) : a;
  endfunction

  assign imem_rdata = memWord(imem_addr, scramble);
  assign imem_ready = (readyMode == 0) ? imem_req :
                      (readyMode == 1) ? (imem_req && (waitCnt == memDelay)) : rndReady;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= 0;
    end else if (!imem_req || imem_ready) begin
      waitCnt <= 0;
    end else begin
      waitCnt <= waitCnt + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic st, input logic [1:0] js, input logic [1:0] bs,
                                 input logic eq, input logic gt, input logic [31:0] jt,
                                 input logic [31:0] rt, input logic [31:0] bt, input logic ev,
                                 input logic [31:0] ei, input logic [31:0] ep, input logic er,
                                 input logic [31:0] ea);
    vec_t v;
    v.stall = st; v.js = js; v.bs = bs; v.eq = eq; v.gt = gt;
    v.jt = jt; v.rt = rt; v.bt = bt;
    v.expValid = ev; v.expInstr = ei; v.expPc = ep; v.expReq = er; v.expAddr = ea;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    stall = 1'b0; JMPSel = 2'b00; BranchSel = 2'b00; eq_flag = 1'b0; gt_flag = 1'b0;
    jmp_target = '0; reg_target = '0; branch_target = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    stall = v.stall; JMPSel = v.js; BranchSel = v.bs; eq_flag = v.eq; gt_flag = v.gt;
    jmp_target = v.jt; reg_target = v.rt; branch_target = v.bt;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " req"}, imem_req, 0);
    checkOutput({tag, " addr"}, imem_addr, 0);
    checkOutput({tag, " instr"}, instr_out, 0);
    checkOutput({tag, " pc"}, pc_out, 0);
    checkOutput({tag, " valid"}, instr_valid, 0);
`ifdef FETCH_COUNT_EN
    checkOutput({tag, " count"}, fetch_count, 0);
`endif
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    #2;
    checkResetState("reset");
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic waitValid(input int budget, output logic found);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
  endtask

  logic        found;
  logic        gotNew;
  logic [31:0] newAddr;
  logic [31:0] expPc;
  logic [31:0] tgt;
  logic [31:0] preAddr;
  logic [31:0] prevInstr;
  logic [31:0] prevPc;
  logic        preReq, preReady, prevValid, taken, redir, stallNow;
  int          nLoads, nXfers, nValid;
  int          lens[3];

  initial begin
    rst = 1'b0;
    clearInputs();
    #3;

    // Directed table: zero-latency memory, data equals address.
    vecs[0]  = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
    vecs[1]  = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h4);
    vecs[2]  = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h4, 32'h4, 1, 32'h8);
    vecs[3]  = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 1, 32'hC);
    vecs[4]  = mkVec(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0, 32'h0);
    vecs[5]  = mkVec(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0, 32'h0);
    vecs[6]  = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'hC, 32'hC, 1, 32'h10);
    vecs[7]  = mkVec(0, 2'b01, 2'b00, 0, 0, 32'h40, 0, 0, 0, 32'h0, 32'hC, 1, 32'h40);
    vecs[8]  = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h40, 32'h40, 1, 32'h44);
    vecs[9]  = mkVec(0, 2'b10, 2'b10, 0, 1, 0, 32'h20, 32'h80, 0, 32'h0, 32'h40, 1, 32'h80);
    vecs[10] = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h80, 32'h80, 1, 32'h84);
    vecs[11] = mkVec(0, 2'b00, 2'b01, 0, 1, 0, 0, 32'h999, 1, 32'h84, 32'h84, 1, 32'h88);
    vecs[12] = mkVec(0, 2'b00, 2'b01, 1, 0, 0, 0, 32'h100, 0, 32'h0, 32'h84, 1, 32'h100);
    vecs[13] = mkVec(0, 2'b11, 2'b11, 1, 1, 32'h7770, 32'h6660, 32'hDEAD0, 1, 32'h100, 32'h100, 1, 32'h104);
    vecs[14] = mkVec(0, 2'b10, 2'b00, 0, 0, 0, 32'h200, 0, 0, 32'h0, 32'h100, 1, 32'h200);
    vecs[15] = mkVec(1, 2'b01, 2'b00, 0, 0, 32'h300, 0, 0, 0, 32'h0, 32'h100, 1, 32'h300);
    vecs[16] = mkVec(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'h100, 0, 32'h0);
    vecs[17] = mkVec(1, 2'b01, 2'b00, 0, 0, 32'h500, 0, 0, 0, 32'h0, 32'h100, 1, 32'h500);
    vecs[18] = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h500, 32'h500, 1, 32'h504);
    vecs[19] = mkVec(0, 2'b01, 2'b00, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h500, 1, 32'hFFFF_FFFC);
    vecs[20] = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h0);
    vecs[21] = mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h4);

    readyMode = 0; scramble = 1'b0;
    doReset();
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d valid", i), instr_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d instr", i), instr_out, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d pc", i), pc_out, vecs[i].expPc);
      checkOutput($sformatf("vec%0d req", i), imem_req, vecs[i].expReq);
      if (vecs[i].expReq) checkOutput($sformatf("vec%0d addr", i), imem_addr, vecs[i].expAddr);
    end
    clearInputs();

    // Ready three cycles late: each address held four cycles, one valid per transfer.
    readyMode = 1; memDelay = 3; scramble = 1'b1;
    doReset();
    lens = '{0, 0, 0};
    nValid = 0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (imem_req) begin
        for (int k = 0; k < 3; k++) if (imem_addr == 32'(k * 4)) lens[k]++;
      end
      if (instr_valid) begin
        checkOutput("delay3 pc", pc_out, 32'(nValid * 4));
        checkOutput("delay3 instr", instr_out, memWord(32'(nValid * 4), 1'b1));
        nValid++;
      end
    end
    for (int k = 0; k < 3; k++) checkOutput($sformatf("delay3 addr%0d hold", k), lens[k], 4);
    checkOutput("delay3 valid count", nValid, 3);

    // Jump while the next request is outstanding: DISCARD drops the old fetch.
    readyMode = 1; memDelay = 2; scramble = 1'b1;
    doReset();
    waitValid(20, found);
    checkOutput("jmp first found", found, 1);
    checkOutput("jmp first pc", pc_out, 32'h0);
    JMPSel = 2'b01; jmp_target = 32'h40;
    tick();
    clearInputs();
    checkOutput("discard valid", instr_valid, 0);
    checkOutput("discard instr", instr_out, 0);
    checkOutput("discard req", imem_req, 1);
    checkOutput("discard old addr", imem_addr, 32'h4);
    gotNew = 1'b0; newAddr = '0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (!gotNew && imem_addr != 32'h4) begin gotNew = 1'b1; newAddr = imem_addr; end
      if (instr_valid) found = 1'b1;
    end
    checkOutput("jmp valid found", found, 1);
    checkOutput("jmp next pc", pc_out, 32'h40);
    checkOutput("jmp next instr", instr_out, memWord(32'h40, 1'b1));
    checkOutput("discard addr switch", newAddr, 32'h40);

    // Stall while the transfer to 0x10 completes: skid then drain.
    readyMode = 0; scramble = 1'b1;
    doReset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (instr_valid && pc_out == 32'hC) found = 1'b1;
    end
    checkOutput("skid setup found", found, 1);
    checkOutput("skid setup addr", imem_addr, 32'h10);
    stall = 1'b1;
    tick();
    checkOutput("skid req low", imem_req, 0);
    checkOutput("skid hold valid", instr_valid, 1);
    checkOutput("skid hold pc", pc_out, 32'hC);
    checkOutput("skid hold instr", instr_out, memWord(32'hC, 1'b1));
    tick();
    checkOutput("skid hold pc2", pc_out, 32'hC);
    stall = 1'b0;
    tick();
    checkOutput("skid drain valid", instr_valid, 1);
    checkOutput("skid drain pc", pc_out, 32'h10);
    checkOutput("skid drain instr", instr_out, memWord(32'h10, 1'b1));
    checkOutput("skid drain addr", imem_addr, 32'h14);
    tick();
    checkOutput("after skid pc", pc_out, 32'h14);

    // Reset in the middle of a transfer, late ready in IDLE, then five fetches.
    readyMode = 1; memDelay = 1; scramble = 1'b0;
    doReset();
    tick();
    tick();
    checkOutput("midxfer ready up", imem_ready, 1);
    readyMode = 2; rndReady = 1'b1;
    rst = 1'b1;
    #2;
    checkResetState("midxfer reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post reset valid", instr_valid, 0);
    checkOutput("post reset req", imem_req, 1);
    checkOutput("post reset addr", imem_addr, 32'h0);
    readyMode = 0;
    nValid = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (instr_valid) nValid++;
    end
    checkOutput("five fetch count", nValid, 5);
    checkOutput("five fetch pc", pc_out, 32'h10);
    checkOutput("five fetch instr", instr_out, 32'h10);
`ifdef FETCH_COUNT_EN
    checkOutput("five fetch fetch_count", fetch_count, 5);
`endif

    // Randomized run against the program-order stream model.
    readyMode = 2; scramble = 1'b1; rndReady = 1'b0;
    doReset();
    expPc = 32'h0;
    prevValid = instr_valid; prevInstr = instr_out; prevPc = pc_out;
    nLoads = 0; nXfers = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      JMPSel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) :
               ($urandom_range(0, 1) == 0 ? 2'b00 : 2'b11);
      BranchSel = 2'($urandom_range(0, 3));
      eq_flag = ($urandom_range(0, 7) == 0);
      gt_flag = ($urandom_range(0, 7) == 0);
      jmp_target = $urandom & 32'hFFFF_FFFC;
      reg_target = $urandom & 32'h0000_FFFC;
      branch_target = $urandom & 32'hFFFF_FFFC;
      rndReady = ($urandom_range(0, 1) == 1);
      #1;
      preReq = imem_req; preAddr = imem_addr; preReady = imem_ready; stallNow = stall;
      taken = ((BranchSel == 2'b01) && eq_flag) || ((BranchSel == 2'b10) && gt_flag);
      redir = taken || (JMPSel == 2'b01) || (JMPSel == 2'b10);
      tgt = taken ? branch_target : ((JMPSel == 2'b01) ? jmp_target : reg_target);
      @(posedge clk);
      #1;
      if (redir) begin
        checkOutput("rand bubble valid", instr_valid, 0);
        checkOutput("rand bubble instr", instr_out, 0);
        expPc = tgt;
      end else if (stallNow) begin
        checkOutput("rand freeze valid", instr_valid, prevValid);
        checkOutput("rand freeze instr", instr_out, prevInstr);
        checkOutput("rand freeze pc", pc_out, prevPc);
      end else if (instr_valid) begin
        checkOutput("rand stream pc", pc_out, expPc);
        checkOutput("rand stream instr", instr_out, memWord(expPc, 1'b1));
        expPc = expPc + 32'h4;
        nLoads++;
      end
      if (preReq && !preReady) begin
        checkOutput("rand req held", imem_req, 1);
        checkOutput("rand addr held", imem_addr, preAddr);
      end
      if (preReq && preReady) nXfers++;
      prevValid = instr_valid; prevInstr = instr_out; prevPc = pc_out;
    end
    checkOutput("rand progress", (nLoads > 100), 1);
    checkOutput("rand loads within transfers", (nLoads <= nXfers), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
